// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the external SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam int unsigned CH_SCREEN = 0;
  localparam int unsigned CH_CPU    = 1;
  localparam int unsigned CH_INIT   = 2;
  localparam int unsigned CH_DMA    = 3;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational winner selection: optional fixed-top channel 0, then round-robin or lowest-index.
module sram_rr_pick
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter bit          PRIO0 = 1'b1,
  parameter bit          RR_EN = 1'b1
) (
  input  logic [NCH-1:0]        req,
  input  logic [idx_w(NCH)-1:0] ptr,
  output logic [NCH-1:0]        win_c,
  output logic                  valid_c
);

  localparam int unsigned IW = idx_w(NCH);

  logic [NCH-1:0] cand;
  logic [IW-1:0]  idx;

  always_comb begin
    win_c   = '0;
    valid_c = 1'b0;
    idx     = '0;
    cand    = req;
    if (PRIO0) cand[0] = 1'b0;

    if (PRIO0 && req[0]) begin
      win_c[0] = 1'b1;
      valid_c  = 1'b1;
    end else if (RR_EN) begin
      // Scan starting one past the last winner, wrapping around.
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = IW'((32'(ptr) + k) % NCH);
        if (!valid_c && cand[idx]) begin
          win_c[idx] = 1'b1;
          valid_c    = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!valid_c && cand[i]) begin
          win_c[i] = 1'b1;
          valid_c  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-master arbiter and strobe/address/data timing generator for the shared external SRAM.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned AW         = 19,
  parameter int unsigned DW         = 8,
  parameter int unsigned ACC_CYCLES = 2,
  parameter bit          PRIO0      = 1'b1,
  parameter bit          RR_EN      = 1'b1
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     sram_a,
  output logic [DW-1:0]     sram_dout,
  output logic              sram_doe,
  input  logic [DW-1:0]     sram_din,
  output logic              sram_rd_n,
  output logic              sram_wr_n
);

  localparam int unsigned IW = idx_w(NCH);
  localparam int unsigned CW = idx_w(ACC_CYCLES);

  arb_state_t     state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [IW-1:0]  cur_ch, cur_ch_d, rr_ptr, rr_ptr_d, widx;
  logic           cur_we, cur_we_d;
  logic [NCH-1:0] win_c, gnt_d, ack_d;
  logic           win_valid_c;
  logic [DW-1:0]  rdata_d, dout_d;
  logic [AW-1:0]  a_d;
  logic           doe_d, rd_n_d, wr_n_d, busy_d;

  sram_rr_pick #(.NCH(NCH), .PRIO0(PRIO0), .RR_EN(RR_EN)) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .win_c   (win_c),
    .valid_c (win_valid_c)
  );

  always_comb begin
    widx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (win_c[i]) widx = IW'(i);
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cur_ch_d = cur_ch;
    cur_we_d = cur_we;
    rr_ptr_d = rr_ptr;
    gnt_d    = '0;
    ack_d    = '0;
    rdata_d  = rdata;
    a_d      = sram_a;
    dout_d   = sram_dout;
    doe_d    = sram_doe;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;

    case (state)
      ARB_IDLE, ARB_DONE: begin
        if (win_valid_c) begin
          state_d  = ARB_SETUP;
          gnt_d    = win_c;
          cur_ch_d = widx;
          cur_we_d = we[widx];
          a_d      = addr[32'(widx)*AW +: AW];
          dout_d   = wdata[32'(widx)*DW +: DW];
          doe_d    = we[widx];
          rd_n_d   = we[widx];
          if (RR_EN && !(PRIO0 && widx == '0)) rr_ptr_d = widx;
        end else begin
          state_d = ARB_IDLE;
          doe_d   = 1'b0;
        end
      end
      ARB_SETUP: begin
        state_d = ARB_ACCESS;
        cnt_d   = '0;
        rd_n_d  = cur_we;
        wr_n_d  = !cur_we;
        doe_d   = cur_we;
      end
      ARB_ACCESS: begin
        doe_d = cur_we;
        if (cnt == CW'(ACC_CYCLES - 1)) begin
          state_d        = ARB_DONE;
          ack_d[cur_ch]  = 1'b1;
          if (!cur_we) rdata_d = sram_din;
        end else begin
          cnt_d  = CW'(cnt + 1'b1);
          rd_n_d = cur_we;
          wr_n_d = !cur_we;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      cur_ch    <= '0;
      cur_we    <= 1'b0;
      rr_ptr    <= IW'(NCH - 1);
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      sram_a    <= '0;
      sram_dout <= '0;
      sram_doe  <= 1'b0;
      sram_rd_n <= 1'b1;
      sram_wr_n <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur_ch    <= cur_ch_d;
      cur_we    <= cur_we_d;
      rr_ptr    <= rr_ptr_d;
      gnt       <= gnt_d;
      ack       <= ack_d;
      rdata     <= rdata_d;
      sram_a    <= a_d;
      sram_dout <= dout_d;
      sram_doe  <= doe_d;
      sram_rd_n <= rd_n_d;
      sram_wr_n <= wr_n_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with default parameters (4 channels, ACC_CYCLES=2, PRIO0=1, RR_EN=1).
module tb_sram_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 8;

  logic              clk28 = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req, we, gnt, ack;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [DW-1:0]     rdata, sram_dout, sram_din;
  logic [AW-1:0]     sram_a;
  logic              busy, sram_doe, sram_rd_n, sram_wr_n;

  int vectors = 0;
  int miscompares = 0;

  sram_arbiter dut (
    .clk28(clk28), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .sram_a(sram_a),
    .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_rd_n(sram_rd_n), .sram_wr_n(sram_wr_n)
  );

  always #5 clk28 = ~clk28;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[ch]            = w;
    addr[ch*AW +: AW] = a;
    wdata[ch*DW +: DW] = d;
  endtask

  int wr_low, doe_hi, ack_cnt, both_low, a_unstable, d_unstable, ack_seen;
  int g1, g3, a1, a3, n_gnt;
  logic [NCH-1:0] gnt_seen [8];
  int gnt_t [8];
  logic [NCH-1:0] exp_ch [7];
  int exp_t [7];

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; sram_din = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("rst_doe", 32'(sram_doe), 32'd0);
    chk("rst_rd_n", 32'(sram_rd_n), 32'd1);
    chk("rst_wr_n", 32'(sram_wr_n), 32'd1);
    rst_n = 1'b1;
    tick();

    // Read on ch1
    set_ch(1, 1'b0, 19'h12345, 8'h00); sram_din = 8'hA5; req[1] = 1'b1;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_addr", 32'(sram_a), 32'h12345);
    chk("rd_setup_rd_n", 32'(sram_rd_n), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    req[1] = 1'b0;
    tick();
    chk("rd_gnt_off", 32'(gnt), 32'h0);
    chk("rd_acc0_rd_n", 32'(sram_rd_n), 32'd0);
    tick();
    chk("rd_acc1_rd_n", 32'(sram_rd_n), 32'd0);
    chk("rd_acc1_ack", 32'(ack), 32'h0);
    tick();
    chk("rd_ack", 32'(ack), 32'h2);
    chk("rd_rdata", 32'(rdata), 32'hA5);
    chk("rd_done_rd_n", 32'(sram_rd_n), 32'd1);
    tick();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_ack_off", 32'(ack), 32'h0);

    // Write on ch2
    set_ch(2, 1'b1, 19'h00400, 8'h3C); req[2] = 1'b1;
    wr_low = 0; doe_hi = 0; ack_cnt = 0; both_low = 0; a_unstable = 0; d_unstable = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t == 0) req[2] = 1'b0;
      if (!sram_wr_n) wr_low++;
      if (sram_doe) begin
        doe_hi++;
        if (sram_a !== 19'h00400) a_unstable++;
        if (sram_dout !== 8'h3C) d_unstable++;
      end
      if (ack[2]) ack_cnt++;
      if (!sram_wr_n && !sram_rd_n) both_low++;
    end
    chk("wr_strobe_cycles", 32'(wr_low), 32'd2);
    chk("wr_doe_cycles", 32'(doe_hi), 32'd4);
    chk("wr_addr_stable", 32'(a_unstable), 32'd0);
    chk("wr_data_stable", 32'(d_unstable), 32'd0);
    chk("wr_ack_count", 32'(ack_cnt), 32'd1);
    chk("wr_no_both_low", 32'(both_low), 32'd0);
    chk("wr_idle_doe", 32'(sram_doe), 32'd0);

    // ch0 fixed priority over ch2, back-to-back
    set_ch(0, 1'b0, 19'h00111, 8'h00); set_ch(2, 1'b0, 19'h00222, 8'h00);
    req[0] = 1'b1; req[2] = 1'b1;
    tick();
    chk("prio_gnt0", 32'(gnt), 32'h1);
    chk("prio_addr0", 32'(sram_a), 32'h00111);
    req[0] = 1'b0;
    tick(); tick(); tick();
    chk("prio_ack0", 32'(ack), 32'h1);
    chk("prio_gnt_in_done", 32'(gnt), 32'h0);
    tick();
    chk("prio_gnt2", 32'(gnt), 32'h4);
    chk("prio_no_idle", 32'(busy), 32'd1);
    chk("prio_addr2", 32'(sram_a), 32'h00222);
    req[2] = 1'b0;
    tick(); tick(); tick();
    chk("prio_ack2", 32'(ack), 32'h4);
    tick();
    chk("prio_idle", 32'(busy), 32'd0);

    // Round-robin from reset, ch0 pre-empts mid-sequence
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    we = '0;
    req = 4'b1110;
    n_gnt = 0;
    for (int t = 0; t < 26; t++) begin
      tick();
      if (gnt != '0) begin
        if (n_gnt < 8) begin gnt_seen[n_gnt] = gnt; gnt_t[n_gnt] = t; end
        n_gnt++;
      end
      if (t == 17) req[0] = 1'b1;
      if (gnt[0]) req[0] = 1'b0;
    end
    req = '0;
    exp_ch = '{4'h2, 4'h4, 4'h8, 4'h2, 4'h4, 4'h1, 4'h8};
    exp_t  = '{0, 4, 8, 12, 16, 20, 24};
    chk("rr_grant_count", 32'(n_gnt), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rr_grant%0d_ch", i), 32'(gnt_seen[i]), 32'(exp_ch[i]));
      chk($sformatf("rr_grant%0d_time", i), 32'(gnt_t[i]), 32'(exp_t[i]));
    end
    for (int t = 0; t < 6; t++) tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // ch3 request withdrawn before grant while ch1 busy
    set_ch(1, 1'b0, 19'h00777, 8'h00); sram_din = 8'h11; req[1] = 1'b1;
    g1 = 0; g3 = 0; a1 = 0; a3 = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (gnt[1]) g1++;
      if (gnt[3]) g3++;
      if (ack[1]) a1++;
      if (ack[3]) a3++;
      if (t == 0) begin req[1] = 1'b0; req[3] = 1'b1; end
      if (t == 1) req[3] = 1'b0;
    end
    chk("cancel_gnt1", 32'(g1), 32'd1);
    chk("cancel_ack1", 32'(a1), 32'd1);
    chk("cancel_gnt3", 32'(g3), 32'd0);
    chk("cancel_ack3", 32'(a3), 32'd0);

    // Reset during write ACCESS
    set_ch(2, 1'b1, 19'h0ABCD, 8'h77); req[2] = 1'b1;
    tick();
    chk("rstw_gnt", 32'(gnt), 32'h4);
    req[2] = 1'b0;
    tick();
    chk("rstw_acc_wr_n", 32'(sram_wr_n), 32'd0);
    chk("rstw_acc_doe", 32'(sram_doe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_wr_n", 32'(sram_wr_n), 32'd1);
    chk("rstw_doe", 32'(sram_doe), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    ack_seen = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (ack != '0) ack_seen++;
    end
    chk("rstw_no_ack", 32'(ack_seen), 32'd0);
    rst_n = 1'b1;
    tick();
    set_ch(1, 1'b0, 19'h1F0F0, 8'h00); sram_din = 8'h5A; req[1] = 1'b1;
    tick();
    chk("post_gnt", 32'(gnt), 32'h2);
    chk("post_addr", 32'(sram_a), 32'h1F0F0);
    req[1] = 1'b0;
    tick(); tick();
    chk("post_no_early_ack", 32'(ack), 32'h0);
    tick();
    chk("post_ack", 32'(ack), 32'h2);
    chk("post_rdata", 32'(rdata), 32'h5A);
    tick();
    chk("post_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Parametrised multi-channel arbiter and timing generator for the shared external video/system SRAM, clocked at clk28. It replaces the ad-hoc romreq/ramreq/screen_fetch muxing with one requester port per master, for example screen fetch, CPU, rom2ram initializer and a future DMA master. It provides selectable priority, programmable access length, and registered strobe/address/data generation for va/vd.

Parameters:
NCH, 4, number of requester channels (>=2)
AW, 19, SRAM address width
DW, 8, SRAM data width
ACC_CYCLES, 2, clk28 cycles of active strobe per access (>=1)
PRIO0, 1, 1 = channel 0 has fixed top priority; 0 = channel 0 joins round-robin
RR_EN, 1, 1 = round-robin among non-fixed channels; 0 = fixed priority, lowest index wins

Ports:
clk28  in  1  system clock
rst_n  in  1  reset (see Behaviour)
req  in  NCH  per-channel request; level, held until ack
we  in  NCH  per-channel write flag; 1 = write
addr  in  NCH*AW  per-channel address; channel i at [i*AW +: AW]
wdata  in  NCH*DW  per-channel write data; channel i at [i*DW +: DW]
gnt  out  NCH  one-cycle one-hot pulse when the channel's access is accepted
ack  out  NCH  one-cycle one-hot pulse when the access completes; rdata is valid with it on reads
rdata  out  DW  read data captured from SRAM; held until the next read completes
busy  out  1  high in any state other than IDLE
sram_a  out  AW  registered SRAM address
sram_dout  out  DW  write data to SRAM
sram_doe  out  1  1 = drive sram_dout onto the data bus
sram_din  in  DW  data bus input
sram_rd_n  out  1  read strobe, active low
sram_wr_n  out  1  write strobe, active low

Behaviour:
- Reset is asynchronous and active-low (rst_n); the clock is clk28.
- Reset values: state IDLE, gnt=0, ack=0, rdata=0, sram_a=0, sram_dout=0, sram_doe=0, sram_rd_n=1, sram_wr_n=1, busy=0.
- Reset round-robin pointer = NCH-1, so channel 1 (or channel 0 when PRIO0=0) wins first.
- Reset asserted mid-access: strobes return inactive immediately; the access is abandoned; no ack is issued.
- States: IDLE, SETUP, ACCESS (counter 0..ACC_CYCLES-1), DONE.
- Arbitration is evaluated in IDLE and DONE on the sampled req vector.
  - PRIO0=1: req[0] always wins.
  - Otherwise, with RR_EN=1, the first requesting channel after the pointer (wrapping NCH-1 -> 0/1) wins, and the pointer is updated to the winner. The pointer is never updated by channel 0 when PRIO0=1.
  - With RR_EN=0, the lowest requesting index wins.
- Winner latched at that edge:
  - addr goes to sram_a; wdata goes to sram_dout; we and the channel index are stored.
  - gnt[w]=1 for exactly the next cycle; the state moves to SETUP.
- SETUP, 1 cycle:
  - Read: sram_rd_n=0.
  - Write: sram_doe=1, sram_wr_n=1 (address/data setup).
- ACCESS, ACC_CYCLES cycles:
  - Read: sram_rd_n=0.
  - Write: sram_wr_n=0, sram_doe=1.
  - On the last ACCESS edge: read captures sram_din into rdata; the state moves to DONE with ack[w]=1.
- DONE, 1 cycle:
  - Strobes high; sram_doe stays 1 for a write (hold time); sram_a is unchanged.
  - Arbitration runs here, so back-to-back accesses are possible. Throughput is 1 access per ACC_CYCLES+2 cycles.
- Latency: req sampled at edge E0 gives gnt during the cycle after E0, and ack/rdata valid during the cycle after edge E0+1+ACC_CYCLES.
- Handshake:
  - A master may drop req before gnt; that cancels the request with no access.
  - Dropping req after gnt is ignored; the access completes and ack is still issued.
  - addr/wdata/we are sampled only at the grant edge.
  - A master that keeps req high in the ack cycle is treated as a new request.
- Simultaneous req and ack on the same channel is legal.
- gnt and ack are never both high for different channels.
- Write and read strobes are never low together.

Decomposition:
- Shared package: add typedef enum arb_state_t {ARB_IDLE, ARB_SETUP, ARB_ACCESS, ARB_DONE} and localparam channel index names (CH_SCREEN=0, CH_CPU=1, CH_INIT=2, CH_DMA=3).
- One sub-module, sram_rr_pick:
  - Combinational winner selection from req, pointer, PRIO0 and RR_EN.
  - Outputs a one-hot winner and a valid flag.
  - The pointer register stays in sram_arbiter.

Test Plan:
- Read, ch1, addr 19'h12345, sram_din=8'hA5, ACC_CYCLES=2 -> gnt[1] 1 cycle after the request edge; sram_rd_n low 3 cycles; ack[1] 4 cycles after the request edge; rdata=8'hA5; busy low after DONE.
- Write, ch2, addr 19'h00400, wdata 8'h3C -> sram_wr_n low exactly 2 cycles; sram_doe high 4 cycles (SETUP..DONE); sram_a and sram_dout stable throughout; ack[2] once.
- req[0] and req[2] rise on the same edge, PRIO0=1 -> ch0 granted first, ch2 granted in ch0's DONE cycle; no idle cycle between them.
- req[1..3] held continuously, RR_EN=1, after reset -> grant order 1,2,3,1,2; req[0] raised mid-sequence pre-empts at the next arbitration point only.
- req[3] pulsed 0 before its grant while ch1 is busy -> no gnt[3] and no ack[3]; ch1 completes normally.
- rst_n asserted during ACCESS of a write -> sram_wr_n=1 and sram_doe=0 immediately; no ack; after release a new read on ch1 completes with standard latency.
